// File: rtl/exp_taylor_engine.sv
// Fixed-point e^x engine: sums up to TERMS Taylor terms with one shared multiplier.
// Optional saturation of the accumulator on overflow is enabled by defining EXP_SAT_EN.
module exp_taylor_engine #(
    parameter int WIDTH = 16,
    parameter int TERMS = 8,
    localparam int TW = $clog2(TERMS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [TW-1:0]    terms,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   result,
    output logic             ovf
);

    localparam int F = WIDTH - 1;
    localparam logic [WIDTH:0] ONE = {2'b01, {F{1'b0}}};

    // Coefficient table k[n] = round(2^F / n); entry 0 is never addressed.
    function automatic logic [TERMS:0][WIDTH-1:0] build_k_rom();
        logic [TERMS:0][WIDTH-1:0] rom;
        longint unsigned num;
        rom = '0;
        for (int n = 1; n <= TERMS; n++) begin
            num = (64'd1 << F) + 64'(n / 2);
            rom[n] = WIDTH'(num / 64'(n));
        end
        return rom;
    endfunction

    localparam logic [TERMS:0][WIDTH-1:0] K_ROM = build_k_rom();

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_MUL_K = 3'd2,
        S_MUL_X = 3'd3,
        S_ADD   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t            r_state;
    logic [WIDTH:0]    r_r;
    logic [WIDTH:0]    r_t;
    logic [WIDTH-1:0]  r_xr;
    logic [TW-1:0]     r_n;
    logic [TW-1:0]     r_nt;
    logic              r_ovf;
    logic              r_ready;
    logic              r_busy;
    logic              r_done;

    logic [TW-1:0]     w_nt_clamp;
    logic [WIDTH-1:0]  w_mul_b;
    logic [2*WIDTH:0]  w_prod;
    logic [WIDTH:0]    w_t_next;
    logic [WIDTH+1:0]  w_sum;

    // Clamp the requested term count into 1..TERMS.
    always_comb begin
        w_nt_clamp = terms;
        if (terms == '0) begin
            w_nt_clamp = TW'(1);
        end else if (terms > TW'(TERMS)) begin
            w_nt_clamp = TW'(TERMS);
        end else begin
            w_nt_clamp = terms;
        end
    end

    // Shared multiplier: coefficient in MUL_K, latched operand otherwise.
    always_comb begin
        w_mul_b = r_xr;
        if (r_state == S_MUL_K) begin
            w_mul_b = K_ROM[r_n];
        end else begin
            w_mul_b = r_xr;
        end
    end

    assign w_prod   = {{WIDTH{1'b0}}, r_t} * {{(WIDTH + 1){1'b0}}, w_mul_b};
    assign w_t_next = (WIDTH + 1)'(w_prod >> F);
    assign w_sum    = {1'b0, r_r} + {1'b0, r_t};

    // Controller and datapath state with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_r     <= '0;
            r_t     <= '0;
            r_xr    <= '0;
            r_n     <= '0;
            r_nt    <= '0;
            r_ovf   <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_xr    <= x;
                        r_nt    <= w_nt_clamp;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_INIT;
                    end
                end
                S_INIT: begin
                    r_t     <= ONE;
                    r_r     <= ONE;
                    r_n     <= TW'(1);
                    r_ovf   <= 1'b0;
                    r_state <= S_MUL_K;
                end
                S_MUL_K: begin
                    r_t     <= w_t_next;
                    r_state <= S_MUL_X;
                end
                S_MUL_X: begin
                    r_t     <= w_t_next;
                    r_state <= S_ADD;
                end
                S_ADD: begin
`ifdef EXP_SAT_EN
                    if (r_ovf || w_sum[WIDTH+1]) begin
                        r_r <= '1;
                    end else begin
                        r_r <= w_sum[WIDTH:0];
                    end
`else
                    r_r <= w_sum[WIDTH:0];
`endif
                    if (w_sum[WIDTH+1]) begin
                        r_ovf <= 1'b1;
                    end
                    r_n <= r_n + TW'(1);
                    if (r_n == r_nt) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_MUL_K;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ready  = r_ready;
    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_r;
    assign ovf    = r_ovf;

endmodule

// File: tb/tb_exp_taylor_engine.sv
// Directed self-checking bench for exp_taylor_engine (WIDTH=16, TERMS=8).
// Expected values are hand-computed; overflow expectation follows EXP_SAT_EN.
module tb_exp_taylor_engine;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] x;
    logic [3:0]  terms;
    logic        ready;
    logic        busy;
    logic        done;
    logic [16:0] result;
    logic        ovf;

    int n_cmp;
    int n_fail;

    exp_taylor_engine #(.WIDTH(16), .TERMS(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .x      (x),
        .terms  (terms),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .result (result),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operation; lat is the cycle number (start edge = 0) in which done is high.
    task automatic run_op(input logic [15:0] xv, input logic [3:0] tv,
                          output int lat, output logic [16:0] res, output logic ov);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        res  = '0;
        ov   = 1'b0;
        @(negedge clk);
        x = xv; terms = tv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; x = 16'h1234; terms = 4'd2;
        for (int c = 1; c <= 100 && !seen; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                seen = 1'b1;
                lat  = c + 1;
                res  = result;
                ov   = ovf;
            end
        end
        n_cmp++;
        if (!seen) begin
            n_fail++;
            $display("FAIL run_op_timeout: done seen=%0d required=1", seen);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 1'b0 || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL done_pulse_end: done=%b ready=%b required done=0 ready=1", done, ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; x = 16'h8000; terms = 4'd8;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready); end
            n_cmp++;
            if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
            n_cmp++;
            if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
            n_cmp++;
            if (result !== 17'h00000) begin n_fail++; $display("FAIL reset_result: got %h want 00000", result); end
            n_cmp++;
            if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_stay_idle: ready=%b busy=%b want ready=1 busy=0", ready, busy);
        end
    endtask

    task automatic test_zero();
        int lat; logic [16:0] res; logic ov;
        run_op(16'h0000, 4'd8, lat, res, ov);
        n_cmp++;
        if (lat !== 26) begin n_fail++; $display("FAIL zero_latency: got %0d want 26", lat); end
        n_cmp++;
        if (res !== 17'h08000) begin n_fail++; $display("FAIL zero_result: got %h want 08000", res); end
        n_cmp++;
        if (ov !== 1'b0) begin n_fail++; $display("FAIL zero_ovf: got %b want 0", ov); end
    endtask

    task automatic test_unit();
        int lat; logic [16:0] res; logic ov;
        run_op(16'h8000, 4'd8, lat, res, ov);
        n_cmp++;
        if (lat !== 26) begin n_fail++; $display("FAIL unit8_latency: got %0d want 26", lat); end
        n_cmp++;
        if (res < 17'h15BE9 || res > 17'h15BF9) begin
            n_fail++; $display("FAIL unit8_result: got %h want 15BF1 +/-8", res);
        end
        n_cmp++;
        if (ov !== 1'b0) begin n_fail++; $display("FAIL unit8_ovf: got %b want 0", ov); end
        run_op(16'h8000, 4'd1, lat, res, ov);
        n_cmp++;
        if (lat !== 5) begin n_fail++; $display("FAIL unit1_latency: got %0d want 5", lat); end
        n_cmp++;
        if (res !== 17'h10000) begin n_fail++; $display("FAIL unit1_result: got %h want 10000", res); end
    endtask

    task automatic test_clamp();
        int lat; logic [16:0] res; logic ov;
        run_op(16'h8000, 4'd0, lat, res, ov);
        n_cmp++;
        if (lat !== 5) begin n_fail++; $display("FAIL clamp0_latency: got %0d want 5", lat); end
        n_cmp++;
        if (res !== 17'h10000) begin n_fail++; $display("FAIL clamp0_result: got %h want 10000", res); end
        run_op(16'h8000, 4'd15, lat, res, ov);
        n_cmp++;
        if (lat !== 26) begin n_fail++; $display("FAIL clamp15_latency: got %0d want 26", lat); end
        n_cmp++;
        if (res < 17'h15BE9 || res > 17'h15BF9) begin
            n_fail++; $display("FAIL clamp15_result: got %h want 15BF1 +/-8", res);
        end
    endtask

    task automatic test_overflow();
        int lat; logic [16:0] res; logic ov; logic [16:0] exp_res;
`ifdef EXP_SAT_EN
        exp_res = 17'h1FFFF;
`else
        exp_res = 17'h1B17A;
`endif
        run_op(16'hFFFF, 4'd8, lat, res, ov);
        n_cmp++;
        if (ov !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", ov); end
        n_cmp++;
        if (res !== exp_res) begin n_fail++; $display("FAIL ovf_result: got %h want %h", res, exp_res); end
        n_cmp++;
        if (lat !== 26) begin n_fail++; $display("FAIL ovf_latency: got %0d want 26", lat); end
    endtask

    task automatic test_back_to_back();
        int first; int second; int ndone;
        first = -1; second = -1; ndone = 0;
        @(negedge clk);
        x = 16'h8000; terms = 4'd1; start = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                ndone++;
                if (first < 0) first = c;
                else if (second < 0) second = c;
            end
        end
        start = 1'b0;
        n_cmp++;
        if (first !== 4) begin n_fail++; $display("FAIL b2b_first_done: got %0d want 4", first); end
        n_cmp++;
        if (second - first !== 6) begin n_fail++; $display("FAIL b2b_interval: got %0d want 6", second - first); end
        n_cmp++;
        if (ndone !== 7) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 7", ndone); end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (ready !== 1'b1 || result !== 17'h10000) begin
            n_fail++; $display("FAIL b2b_final: ready=%b result=%h want ready=1 result=10000", ready, result);
        end
    endtask

    task automatic test_abort();
        int ndone; int lat; logic [16:0] res; logic ov;
        ndone = 0;
        @(negedge clk);
        x = 16'h8000; terms = 4'd8; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_before: got %b want 1", busy); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++;
        if (ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_idle: ready=%b busy=%b want ready=1 busy=0", ready, busy);
        end
        n_cmp++;
        if (result !== 17'h00000) begin n_fail++; $display("FAIL abort_result: got %h want 00000", result); end
        n_cmp++;
        if (ovf !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL abort_flags: ovf=%b done=%b want 0 0", ovf, done);
        end
        repeat (30) begin
            @(posedge clk); #1;
            if (done === 1'b1) ndone++;
        end
        n_cmp++;
        if (ndone !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses want 0", ndone); end
        run_op(16'h8000, 4'd8, lat, res, ov);
        n_cmp++;
        if (res < 17'h15BE9 || res > 17'h15BF9) begin
            n_fail++; $display("FAIL abort_rerun_result: got %h want 15BF1 +/-8", res);
        end
        n_cmp++;
        if (lat !== 26) begin n_fail++; $display("FAIL abort_rerun_latency: got %0d want 26", lat); end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        start  = 1'b0;
        x      = '0;
        terms  = '0;
        test_reset();
        test_zero();
        test_unit();
        test_clamp();
        test_overflow();
        test_back_to_back();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/exp_taylor_engine.md
# exp_taylor_engine

Parametrised fixed-point e^x engine: a multi-cycle controller plus datapath that sums up to TERMS Taylor terms using a single shared multiplier. Each term takes three cycles: coefficient multiply, x multiply, accumulate. It generalises the fixed-term exponential controller with the following additions:
- configurable width and maximum term count;
- a runtime term count;
- a coefficient ROM generated at elaboration;
- an overflow flag with optional saturation.

It sits as a slave compute unit behind a start/done handshake.

## Interface
- WIDTH, 16, operand width; x is Q1.F with F = WIDTH-1; legal range 8..30
- TERMS, 8, maximum number of series terms beyond the constant 1; legal range 2..15
- TW, $clog2(TERMS+1), width of the terms input (derived; not overridden)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- x  in  WIDTH  operand, unsigned Q1.F, 0 ≤ x < 2
- terms  in  TW  requested term count, latched with x
- ready  out  1  high in IDLE
- busy  out  1  high from INIT through the last ADD
- done  out  1  one-cycle pulse when the result is valid
- result  out  WIDTH+1  e^x, unsigned Q2.F
- ovf  out  1  accumulation exceeded the Q2.F range during the last operation

## Operation
- State machine states:
  - IDLE → INIT when start=1; otherwise stay in IDLE.
  - INIT → MUL_K.
  - MUL_K → MUL_X.
  - MUL_X → ADD.
  - ADD → DONE if n == nt; otherwise ADD → MUL_K.
  - DONE → IDLE unconditionally.
- IDLE with start=1:
  - Latch x into xr.
  - Latch nt = clamp(terms, 1, TERMS); 0 maps to 1, and values above TERMS map to TERMS.
- INIT:
  - Set t = 1.0 (1<<F), r = 1.0, n = 1.
  - Clear the ovf flag.
- MUL_K:
  - t ← (t · k[n]) >> F, truncated.
  - k[n] = round(2^F / n) is a WIDTH-bit ROM built by a constant function at elaboration. k[1] = 2^F.
- MUL_X:
  - t ← (t · xr) >> F, truncated.
  - The order (coefficient first, then x) keeps t_n = x^n/n! ≤ 2 so it fits WIDTH+1 bits. The intermediate product is 2·WIDTH+1 bits.
- ADD:
  - r ← r + t, computed WIDTH+2 bits wide.
  - If the carry into bit WIDTH+1 is set, set the sticky ovf flag.
  - Increment n.
- A single multiplier is muxed between k[n] and xr by state.
- result drives r. It holds its value from DONE until the next INIT.
- start is ignored outside IDLE. x and terms may change freely after the accepting cycle.
- rst at any time (mid-operation included):
  - state returns to IDLE;
  - r, t, xr, n, nt and ovf clear;
  - no done pulse is produced.

## Timing
- Reset values:
  - ready=1, busy=0, done=0, result=0, ovf=0.
- Latency from start:
  - Define cycle 0 as the rising edge where start is sampled in IDLE.
  - INIT occupies cycle 1.
  - Terms occupy cycles 2 .. 3·nt+1.
  - done=1 during cycle 3·nt+2 (26 cycles for nt=8).
- Back-to-back:
  - ready returns high the cycle after DONE.
  - A new start may be accepted then.
  - Minimum issue interval is 3·nt+3 cycles.
- At most one done pulse is produced per accepted start.

## Configuration
- EXP_SAT_EN
  - Defined: once ovf is set, r saturates to all-ones (2^(WIDTH+1)-1). Further ADDs keep it saturated, and result reads all-ones.
  - Undefined: r wraps modulo 2^(WIDTH+1). ovf is still reported.

## Test plan
- Reset:
  - Stimulus: assert rst for 2 cycles with start=1.
  - Expected: ready=1, busy=0, done=0, result=0, ovf=0, and no transition out of IDLE.
- Zero operand:
  - Stimulus: x=0x0000, terms=8.
  - Expected: done at cycle 26, result=0x08000 (1.0), ovf=0.
- Unit operand, full and minimum term counts:
  - Stimulus: x=0x8000 (1.0), terms=8.
  - Expected: result within ±8 LSB of 0x15BF1 (e·2^15).
  - Stimulus: same x with terms=1.
  - Expected: result=0x10000 and done at cycle 5.
- Term-count clamping and start masking:
  - Stimulus: terms=0 with any x.
  - Expected: behaves as terms=1.
  - Stimulus: terms=15 (above TERMS).
  - Expected: done at cycle 26.
  - Stimulus: start held high throughout.
  - Expected: no re-acceptance before ready.
- Overflow:
  - Stimulus: x=0xFFFF (≈2.0), terms=8.
  - Expected: ovf=1.
  - Expected with EXP_SAT_EN: result=0x1FFFF.
  - Expected without it: result equals the wrapped sum.
- Abort:
  - Stimulus: rst asserted in the MUL_X of term 3.
  - Expected: IDLE next cycle with result=0 and no done pulse.
  - Stimulus: a following start with x=0x8000, terms=8.
  - Expected: the correct e result.
